bram_array: RTL and testbench
=============================

Name: bram_array

Overview:
- Storage stage directly downstream of the Wishbone slave interface. It consumes that interface's address, read and write strobes and write data, and returns the read data.
- Holds a 2^ADDR_WIDTH x 32-bit synchronous memory with 1-cycle read latency.
- After every reset it runs a clear sequence that zeroes every word. While clearing it asserts busy_o so the upstream interface stalls the bus.

Parameters:
- ADDR_WIDTH, 8, word address width; depth = 2^ADDR_WIDTH words.
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.

Ports:
- clk_i  input  1  clock; all logic on rising edge.
- rst_i  input  1  reset, synchronous, active-low (0 = reset).
- addr_i  input  ADDR_WIDTH  word address for the current read or write.
- read_i  input  1  read strobe, single-cycle pulse per access.
- read_data_o  output  DATA_WIDTH  read data, valid in the cycle after read_i.
- read_valid_o  output  1  1-cycle pulse marking read_data_o valid.
- write_i  input  1  write strobe, single-cycle pulse per access.
- write_data_i  input  DATA_WIDTH  write data.
- busy_o  output  1  high while clearing; upstream must not issue accesses.

Behaviour:
- Reset (rst_i=0 at a rising edge):
  - FSM enters CLEAR and the clear counter goes to 0.
  - read_data_o=0, read_valid_o=0, busy_o=1.
  - Memory contents are not guaranteed until CLEAR completes.
- FSM states: CLEAR and READY.
- CLEAR:
  - Each cycle writes 0 to mem[counter] and increments the counter.
  - When counter = 2^ADDR_WIDTH-1 has been written, the next state is READY.
  - CLEAR lasts exactly 2^ADDR_WIDTH cycles after reset deassertion (256 by default).
  - busy_o is registered: high for all CLEAR cycles, low from the first READY cycle.
- read_i or write_i asserted in CLEAR: ignored. No memory update, no read_valid_o.
- Reset asserted mid-CLEAR or mid-READY: restarts CLEAR from address 0. Any pending read_valid_o is cancelled, so it is 0 in the cycle after the reset edge.
- READY write: write_i=1 at edge N stores write_data_i at mem[addr_i]. The data is visible to a read issued at edge N+1.
- READY read:
  - read_i=1 at edge N: read_data_o = mem[addr_i] and read_valid_o=1 during cycle N+1.
  - read_valid_o returns to 0 at N+2 unless another read is issued.
- read_data_o holds its last read value until the next read. Writes never change read_data_o.
- read_i and write_i both 1 in one cycle:
  - The write is performed.
  - The read returns the OLD contents (read-first).
  - read_valid_o still pulses.
- Back-to-back reads every cycle: one read_valid_o per read, addresses returned in issue order with no bubbles.
- Addresses wrap naturally within ADDR_WIDTH bits; no out-of-range condition exists.
- The memory array has no reset (BRAM inference). Only the FSM, counter and output registers are reset.

Optional Feature:
- Macro: BRAM_ARRAY_PARITY_EN.
- When defined:
  - Each word stores DATA_WIDTH/8 extra even-parity bits, one per byte, computed on write. CLEAR writes parity 0.
  - New input parity_inject_i (1 bit). When high during a write, the stored parity bit 0 is inverted.
  - On every read, parity is recomputed and compared with the stored bits.
  - Any mismatch sets new output parity_err_o (1 bit) in the same cycle read_valid_o is asserted.
  - parity_err_o is sticky until reset; its reset value is 0.
- When undefined: no parity storage, no parity_inject_i or parity_err_o ports, and behaviour is otherwise identical.

Test Plan:
- Release reset at cycle 0 -> busy_o=1 for exactly 256 cycles, then 0. Reads of addresses 0x00, 0x7F and 0xFF return 0x00000000.
- After CLEAR: write 0xDEADBEEF to 0x10, then read 0x10 next cycle -> read_valid_o pulses 1 cycle later with read_data_o=0xDEADBEEF.
- Write 0x11111111 to 0x20, then in one cycle assert read+write to 0x20 with 0x22222222 -> read returns 0x11111111. A following read returns 0x22222222.
- Write 0xA5A5A5A5 to 0x05, then assert rst_i=0 for 1 cycle 100 cycles into READY -> busy_o=1 for 256 more cycles, and a read of 0x05 afterwards returns 0x00000000.
- Reads issued at 0x00..0x03 on consecutive cycles after writing 1..4 -> read_valid_o high 4 consecutive cycles with data 1, 2, 3, 4. Strobes asserted during CLEAR produce no read_valid_o and no writes.
- BRAM_ARRAY_PARITY_EN:
  - Write 0x000000FF to 0x30 with parity_inject_i=1, then read 0x30 -> parity_err_o=1 with read_valid_o and stays 1.
  - The same sequence with parity_inject_i=0 -> parity_err_o stays 0.

Source files
------------

// File: rtl/bram_array.sv
// Word-addressed synchronous memory behind the Wishbone slave, with a zeroing sweep after every reset.
// Optional per-byte even parity with error injection: define BRAM_ARRAY_PARITY_EN.
module bram_array #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic                  read_i,
  output logic [DATA_WIDTH-1:0] read_data_o,
  output logic                  read_valid_o,
  input  logic                  write_i,
  input  logic [DATA_WIDTH-1:0] write_data_i,
`ifdef BRAM_ARRAY_PARITY_EN
  input  logic                  parity_inject_i,
  output logic                  parity_err_o,
`endif
  output logic                  busy_o
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {CLEAR, READY} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic                    busy_q, busy_d;
  logic                    rvalid_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    we, re;
  logic [ADDR_WIDTH-1:0]   waddr;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  // Single write port shared by the clear sweep and normal writes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    we      = 1'b0;
    re      = 1'b0;
    waddr   = addr_i;
    wdata   = write_data_i;
    case (state_q)
      CLEAR: begin
        we     = 1'b1;
        waddr  = cnt_q;
        wdata  = '0;
        cnt_d  = cnt_q + 1'b1;
        busy_d = 1'b1;
        if (&cnt_q) begin
          state_d = READY;
          busy_d  = 1'b0;
        end
      end
      default: begin
        we     = write_i;
        re     = read_i;
        busy_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q  <= CLEAR;
      cnt_q    <= '0;
      busy_q   <= 1'b1;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      rvalid_q <= re;
      if (re) rdata_q <= mem[addr_i];
    end
  end

  // No reset on the array so it maps onto block RAM; read-first falls out of the NBA ordering.
  always_ff @(posedge clk_i) begin
    if (we && rst_i) mem[waddr] <= wdata;
  end

  assign read_data_o  = rdata_q;
  assign read_valid_o = rvalid_q;
  assign busy_o       = busy_q;

`ifdef BRAM_ARRAY_PARITY_EN
  localparam int NB = DATA_WIDTH / 8;

  function automatic logic [NB-1:0] byte_par(input logic [DATA_WIDTH-1:0] d);
    logic [NB-1:0] p;
    for (int b = 0; b < NB; b++) p[b] = ^d[b*8 +: 8];
    return p;
  endfunction

  logic [NB-1:0] par_mem [DEPTH];
  logic [NB-1:0] wpar;
  logic [NB-1:0] rpar_q;
  logic          perr_q;
  logic          perr_now;

  always_comb begin
    wpar    = byte_par(wdata);
    wpar[0] = wpar[0] ^ (parity_inject_i && state_q == READY);
  end

  always_ff @(posedge clk_i) begin
    if (we && rst_i) par_mem[waddr] <= wpar;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      rpar_q <= '0;
      perr_q <= 1'b0;
    end else begin
      if (re) rpar_q <= par_mem[addr_i];
      perr_q <= parity_err_o;
    end
  end

  // Check runs on the registered word so the error lines up with read_valid_o.
  assign perr_now     = rvalid_q && (byte_par(rdata_q) != rpar_q);
  assign parity_err_o = perr_q | perr_now;
`endif
endmodule

// File: tb/tb_bram_array.sv
// Directed bench for bram_array: spec-level memory model checked every cycle plus literal expectations.
module tb_bram_array;
  logic        clk = 1'b0;
  logic        rst_n, rd, wr;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic [31:0] read_data;
  logic        read_valid, busy;
  bit          pinj;
`ifdef BRAM_ARRAY_PARITY_EN
  logic        perr;
`endif

  always #5 clk = ~clk;

  bram_array #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst_n), .addr_i(addr), .read_i(rd),
    .read_data_o(read_data), .read_valid_o(read_valid),
    .write_i(wr), .write_data_i(wdata),
`ifdef BRAM_ARRAY_PARITY_EN
    .parity_inject_i(pinj), .parity_err_o(perr),
`endif
    .busy_o(busy)
  );

  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: reset starts a 256-cycle clear; afterwards plain read-first word memory.
  logic [31:0] mem_m [256];
  bit          inj_m [256];
  int          clr_left = 0;
  bit          m_busy, m_valid, m_perr, chk_en = 0;
  logic [31:0] m_data;

  always @(posedge clk) begin
    if (!rst_n) begin
      clr_left = 256; m_busy = 1; m_valid = 0; m_data = 0; m_perr = 0; chk_en = 1;
    end else if (clr_left > 0) begin
      clr_left--;
      m_valid = 0;
      if (clr_left == 0) begin
        for (int i = 0; i < 256; i++) begin mem_m[i] = 0; inj_m[i] = 0; end
        m_busy = 0;
      end
    end else begin
      m_valid = rd;
      if (rd) begin
        m_data = mem_m[addr];
        if (inj_m[addr]) m_perr = 1;
      end
      if (wr) begin mem_m[addr] = wdata; inj_m[addr] = pinj; end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", {31'd0, busy}, {31'd0, m_busy});
      chk("valid", {31'd0, read_valid}, {31'd0, m_valid});
      chk("rdata", read_data, m_data);
`ifdef BRAM_ARRAY_PARITY_EN
      chk("perr", {31'd0, perr}, {31'd0, m_perr});
`endif
    end
  end

  task automatic cyc(input bit r, input bit w, input logic [7:0] a, input logic [31:0] d, input bit pi);
    rd = r; wr = w; addr = a; wdata = d; pinj = pi;
    @(posedge clk); #2;
    rd = 0; wr = 0; pinj = 0;
  endtask

  task automatic wait_clear(output int n);
    n = 0;
    while (busy === 1'b1 && n < 1000) begin
      n++;
      @(posedge clk); #2;
    end
  endtask

  int n;
  logic [7:0] clr_addrs [3] = '{8'h00, 8'h7F, 8'hFF};

  initial begin
    rst_n = 0; rd = 0; wr = 0; addr = 0; wdata = 0; pinj = 0;
    repeat (2) @(posedge clk);
    #1 chk("rst_busy", {31'd0, busy}, 32'd1);
    chk("rst_valid", {31'd0, read_valid}, 32'd0);
    chk("rst_rdata", read_data, 32'd0);
    #1 rst_n = 1;
    wait_clear(n);
    chk("clear_len", n, 256);

    foreach (clr_addrs[i]) begin
      cyc(1, 0, clr_addrs[i], 0, 0);
      #1 chk("clr_rd", read_data, 32'h0);
      chk("clr_rd_valid", {31'd0, read_valid}, 32'd1);
    end

    cyc(0, 1, 8'h10, 32'hDEADBEEF, 0);
    cyc(1, 0, 8'h10, 0, 0);
    #1 chk("wr_rd", read_data, 32'hDEADBEEF);
    chk("wr_rd_valid", {31'd0, read_valid}, 32'd1);
    @(posedge clk); #2;
    chk("valid_drop", {31'd0, read_valid}, 32'd0);
    chk("rdata_hold", read_data, 32'hDEADBEEF);

    cyc(0, 1, 8'h20, 32'h11111111, 0);
    cyc(1, 1, 8'h20, 32'h22222222, 0);
    #1 chk("read_first", read_data, 32'h11111111);
    cyc(1, 0, 8'h20, 0, 0);
    #1 chk("after_rw", read_data, 32'h22222222);

    for (int i = 0; i < 4; i++) cyc(0, 1, i[7:0], i + 1, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, i[7:0], 0, 0);
      #1 chk("burst", read_data, i + 1);
      chk("burst_valid", {31'd0, read_valid}, 32'd1);
    end
    cyc(0, 1, 8'h40, 32'h12345678, 0);
    #1 chk("wr_no_rdata", read_data, 32'd4);

    // Reset mid-READY with a read in flight at the same edge.
    cyc(0, 1, 8'h05, 32'hA5A5A5A5, 0);
    repeat (100) begin @(posedge clk); #2; end
    rd = 1; addr = 8'h05; rst_n = 0;
    @(posedge clk); #2;
    rst_n = 1; rd = 0;
    #1 chk("rst_cancel_valid", {31'd0, read_valid}, 32'd0);
    for (int i = 0; i < 3; i++) cyc(1, 1, 8'h05, 32'hFFFFFFFF, 0);
    wait_clear(n);
    chk("clear_len2", n + 3, 256);
    cyc(1, 0, 8'h05, 0, 0);
    #1 chk("cleared_05", read_data, 32'h0);

`ifdef BRAM_ARRAY_PARITY_EN
    cyc(0, 1, 8'h30, 32'h000000FF, 0);
    cyc(1, 0, 8'h30, 0, 0);
    #1 chk("par_clean", {31'd0, perr}, 32'd0);
    cyc(0, 1, 8'h30, 32'h000000FF, 1);
    cyc(1, 0, 8'h30, 0, 0);
    #1 chk("par_err", {31'd0, perr}, 32'd1);
    chk("par_err_valid", {31'd0, read_valid}, 32'd1);
    repeat (3) begin @(posedge clk); #2; end
    chk("par_sticky", {31'd0, perr}, 32'd1);
`endif

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
